// File: rtl/oqpsk_pulse_shaper.sv
// oqpsk_pulse_shaper: half-sine O-QPSK chip-pair shaper producing signed I/Q DAC samples.
// The Q rail lags I by half a pulse (4 samples); one chip pair is consumed per 8 sample ticks.
module oqpsk_pulse_shaper #(
    parameter int unsigned OUT_W = 5,
    parameter int unsigned AMP   = 15
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    sample_en,
    input  logic                    chip_valid,
    output logic                    chip_ready,
    input  logic [1:0]              chip_pair,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    out_valid,
    output logic                    busy
);
    localparam int unsigned PEAK = (1 << (OUT_W - 1)) - 1;
    // round(AMP*sin(pi*k/8)) for k = 1..3, using Q16 sine constants
    localparam int unsigned S1 = (AMP * 25080 + 32768) >> 16;
    localparam int unsigned S2 = (AMP * 46341 + 32768) >> 16;
    localparam int unsigned S3 = (AMP * 60547 + 32768) >> 16;

    generate
        if (AMP > PEAK) begin : g_amp_check
            $error("oqpsk_pulse_shaper: AMP does not fit in signed OUT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              phase, phase_nxt;
    logic                    i_act, i_act_nxt;
    logic                    q_act, q_act_nxt;
    logic                    i_chip, i_chip_nxt;
    logic                    q_chip, q_chip_nxt;
    logic                    q_pend, q_pend_nxt;
    logic signed [OUT_W-1:0] i_out_nxt, q_out_nxt;
    logic                    out_valid_nxt, busy_nxt;
    logic                    transfer;
    logic                    q_load;
    logic                    i_use_act, i_use_chip;
    logic                    q_use_act, q_use_chip;

    function automatic logic signed [OUT_W-1:0] rom_at(input logic [2:0] k);
        case (k)
            3'd1, 3'd7: rom_at = OUT_W'(S1);
            3'd2, 3'd6: rom_at = OUT_W'(S2);
            3'd3, 3'd5: rom_at = OUT_W'(S3);
            3'd4:       rom_at = OUT_W'(AMP);
            default:    rom_at = '0;
        endcase
    endfunction

    function automatic logic signed [OUT_W-1:0] shape(input logic act, input logic chip,
                                                      input logic [2:0] k);
        logic signed [OUT_W-1:0] mag;
        mag = rom_at(k);
        if (!act)
            shape = '0;
        else if (chip)
            shape = mag;
        else
            shape = -mag;
    endfunction

    assign chip_ready = sample_en && (phase == 3'd0) && (state == IDLE || state == RUN);
    assign transfer   = chip_valid && chip_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (sample_en) begin
            case (state)
                IDLE:    if (transfer) state_nxt = RUN;
                RUN:     if (phase == 3'd0 && !transfer) state_nxt = TAIL;
                TAIL:    if (phase == 3'd3) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and output next values; new chips are bypassed into the current sample
    always_comb begin
        phase_nxt     = phase;
        i_act_nxt     = i_act;
        q_act_nxt     = q_act;
        i_chip_nxt    = i_chip;
        q_chip_nxt    = q_chip;
        q_pend_nxt    = q_pend;
        i_out_nxt     = i_out;
        q_out_nxt     = q_out;
        out_valid_nxt = 1'b0;
        busy_nxt      = busy;
        q_load        = (state == RUN) && (phase == 3'd4);
        i_use_act     = transfer || i_act;
        i_use_chip    = transfer ? chip_pair[0] : i_chip;
        q_use_act     = q_load || q_act;
        q_use_chip    = q_load ? q_pend : q_chip;
        if (sample_en) begin
            out_valid_nxt = 1'b1;
            busy_nxt      = transfer || (state != IDLE);
            if ((state == IDLE && !transfer) || (state == TAIL && phase == 3'd3))
                phase_nxt = 3'd0;
            else
                phase_nxt = phase + 3'd1;
            if (transfer) begin
                i_chip_nxt = chip_pair[0];
                q_pend_nxt = chip_pair[1];
                i_act_nxt  = 1'b1;
            end else if (state == RUN && phase == 3'd0) begin
                i_act_nxt = 1'b0;
            end
            if (q_load) begin
                q_chip_nxt = q_pend;
                q_act_nxt  = 1'b1;
            end
            if (state == TAIL && phase == 3'd3)
                q_act_nxt = 1'b0;
            i_out_nxt = shape(i_use_act, i_use_chip, phase);
            q_out_nxt = shape(q_use_act, q_use_chip, phase + 3'd4);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase     <= 3'd0;
            i_act     <= 1'b0;
            q_act     <= 1'b0;
            i_chip    <= 1'b0;
            q_chip    <= 1'b0;
            q_pend    <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            phase     <= phase_nxt;
            i_act     <= i_act_nxt;
            q_act     <= q_act_nxt;
            i_chip    <= i_chip_nxt;
            q_chip    <= q_chip_nxt;
            q_pend    <= q_pend_nxt;
            i_out     <= i_out_nxt;
            q_out     <= q_out_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: doc/oqpsk_pulse_shaper.md
Name: oqpsk_pulse_shaper

Overview:
Transmit-side counterpart of the IQ demodulator's matched FIR front end. It takes O-QPSK chip pairs (I chip, Q chip) over a valid/ready handshake and produces half-sine shaped signed I/Q baseband samples at the DAC sample rate. The Q rail is offset by half a pulse, which is 4 samples. Output format matches the 5-bit signed sample words consumed by the receive path, so TX-to-RX loopback needs no glue.

Parameters:
OUT_W, 5, width of signed two's-complement i_out/q_out.
AMP, 15, peak half-sine amplitude. Must be <= 2^(OUT_W-1)-1. Elaboration fails otherwise.

Ports:
clk  in  1  single clock; all logic on rising edge
resetn  in  1  synchronous, active-low reset
sample_en  in  1  DAC sample strobe; the block advances only on cycles where this is 1
chip_valid  in  1  chip_pair is valid
chip_ready  out  1  combinational; transfer = chip_valid & chip_ready
chip_pair  in  2  [0] = I chip, [1] = Q chip; 1 maps to +pulse, 0 maps to -pulse
i_out  out  OUT_W  shaped I sample, signed
q_out  out  OUT_W  shaped Q sample, signed
out_valid  out  1  registered; 1 for one cycle after each sample_en tick
busy  out  1  registered; 1 while any pulse is in progress (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
  - resetn=0 at an edge gives: state=IDLE, phase=0, i_act=q_act=0, q_pend cleared, i_out=q_out=0, out_valid=0, busy=0.
  - This applies mid-pulse too: the pulse is truncated and no residue remains.
- ROM: rom[k] = round(AMP*sin(pi*k/8)) for k=0..7. With AMP=15 this is 0,6,11,14,15,14,11,6.
- Phase counter: 3 bits, 0..7. It increments and wraps on each sample_en tick in RUN or TAIL, and is held at 0 in IDLE.
- Hold rule: when sample_en=0, all state and outputs hold, chip_ready=0, and out_valid=0 on the next cycle.
- chip_ready = sample_en & (phase==0) & (state==IDLE | state==RUN).
- Sample tick at phase p, with values registered at that edge:
  - On a transfer at p=0: i_chip <- chip_pair[0], q_pend <- chip_pair[1], i_act <- 1.
  - At p=4 in RUN: q_chip <- q_pend, q_act <- 1.
  - i_out = i_act ? (i_chip ? +rom[p] : -rom[p]) : 0. The newly accepted chip is used in the same tick (bypass).
  - q_out = q_act ? (q_chip ? +rom[(p+4)%8] : -rom[(p+4)%8]) : 0. The newly loaded q_chip is also bypassed.
- Latency: the first I sample appears on out_valid one cycle after the accepting tick. The Q pulse starts 4 ticks after its I pulse.
- State machine:
  - IDLE -> RUN on a transfer.
  - RUN, p=0, transfer: stay RUN. Back-to-back pulses, one pair per 8 ticks, with no gap.
  - RUN, p=0, no transfer (underrun): go to TAIL and set i_act=0. The previous Q pulse, if active, keeps playing rom[4..7] over p=0..3.
  - TAIL, tick at p=3: go to IDLE, phase=0, q_act=0.
  - chip_valid during TAIL is not accepted, since chip_ready=0. It is accepted on the first tick in IDLE.
- busy = (state != IDLE), registered.
- The block performs no saturation. The AMP bound guarantees that ±rom fits in OUT_W.

Test Plan:
1. Reset with sample_en=1 and chip_valid=0 -> i_out=q_out=0, busy=0, chip_ready=1 on every tick. Assert resetn=0 for one cycle mid-pulse -> next cycle all outputs are 0 and busy=0.
2. Single pair {Q=1,I=1}, sample_en=1 continuously -> i_out = 0,6,11,14,15,14,11,6 then 0. q_out = 0,0,0,0,0,6,11,14,15,14,11,6 then 0. busy is high for exactly 12 ticks.
3. Continuous pairs with I=1,0,1 and Q=0 -> i_out = 0,6,...,6,0,-6,-11,-14,-15,...,0,6,... with no gap. chip_ready pulses exactly every 8 ticks. q_out is negative half-sines starting at tick 4.
4. sample_en asserted every 3rd cycle with the scenario-2 stimulus -> the same sample sequence as scenario 2, one value per tick. Outputs are stable between ticks, and out_valid is high only on the cycle after each tick.
5. Pair A accepted, then chip_valid raised for pair B during TAIL -> B is not accepted until the IDLE tick. A's Q tail completes as 15,14,11,6. B's I pulse starts on the following tick from 0.
6. Pair {Q=0,I=0} with AMP=7 -> i_out = 0,-3,-5,-6,-7,-6,-5,-3 and q_out is the same sequence delayed 4 ticks.
